// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and frame constants.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Odd parity: the data byte plus its parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Received-byte bus from ps2_rx to the keyboard consumer on the same ps2_clk.
interface ps2_rx_if;

    logic [7:0] key_data;
    logic       key_data_en;
    logic       frame_err;

    modport master (output key_data, output key_data_en, output frame_err);
    modport slave  (input  key_data, input  key_data_en, input  frame_err);

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus a level filter that needs FILTER_LEN equal samples to switch.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic ps2_clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_level
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    // NOTE: all flops reset to the idle line level (1) so no false edge appears on release.
    always_ff @(posedge ps2_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_line};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: filtered lines, frame FSM, inactivity timeout.
// Define PS2_RX_PARITY_CHECK_EN to drop bytes whose odd parity fails.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       ps2_clk,
    input  logic       rst_n,
    input  logic       ps2_line_clk_i,
    input  logic       ps2_line_data_i,
    output logic [7:0] ps2_key_data_o,
    output logic       ps2_key_data_en_o,
    output logic       ps2_frame_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic w_clk_f;
    logic w_data_f;
    logic w_fall;
    logic w_to_hit;
    logic w_parity_ok;

    logic                 r_clk_prev;
    ps2_state_e           r_state,    w_state_nxt;
    logic [2:0]           r_bit_cnt,  w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic [TW-1:0]        r_to_cnt,   w_to_cnt_nxt;
    logic [7:0]           r_key_data, w_key_data_nxt;
    logic                 r_en,       w_en_nxt;
    logic                 r_err,      w_err_nxt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .ps2_clk (ps2_clk),
        .rst_n   (rst_n),
        .i_line  (ps2_line_clk_i),
        .o_level (w_clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .ps2_clk (ps2_clk),
        .rst_n   (rst_n),
        .i_line  (ps2_line_data_i),
        .o_level (w_data_f)
    );

    assign w_fall   = r_clk_prev & ~w_clk_f;
    assign w_to_hit = (r_state != IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_RX_PARITY_CHECK_EN
    logic r_parity;

    always_ff @(posedge ps2_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_fall && r_state == PARITY) begin
            r_parity <= w_data_f;
        end
    end

    assign w_parity_ok = odd_parity_ok(r_shift, r_parity);
`else
    // The parity bit is still clocked through the PARITY state, just never judged.
    assign w_parity_ok = 1'b1;
`endif

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_key_data_nxt = r_key_data;
        w_en_nxt       = 1'b0;
        w_err_nxt      = 1'b0;

        if (r_state == IDLE || w_fall) begin
            w_to_cnt_nxt = '0;
        end else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
            w_to_cnt_nxt = r_to_cnt + 1'b1;
        end else begin
            w_to_cnt_nxt = r_to_cnt;
        end

        if (w_to_hit) begin
            w_state_nxt  = IDLE;
            w_to_cnt_nxt = '0;
            w_err_nxt    = 1'b1;
        end else if (w_fall) begin
            unique case (r_state)
                IDLE: begin
                    if (w_data_f == START_BIT) begin
                        w_state_nxt   = DATA;
                        w_bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    w_shift_nxt   = {w_data_f, r_shift[DATA_BITS-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                        w_state_nxt = PARITY;
                    end
                end
                PARITY: w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    if (w_data_f == STOP_BIT && w_parity_ok) begin
                        w_key_data_nxt = r_shift;
                        w_en_nxt       = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ps2_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_prev <= 1'b1;
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_to_cnt   <= '0;
            r_key_data <= 8'h00;
            r_en       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_f;
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_key_data <= w_key_data_nxt;
            r_en       <= w_en_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign ps2_key_data_o    = r_key_data;
    assign ps2_key_data_en_o = r_en;
    assign ps2_frame_err_o   = r_err;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frames, back-to-back, parity, glitch, timeout, mid-frame reset.
module tb_ps2_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 200;
    localparam int HALF_BIT       = 20;
    localparam int PIPE           = 2 + FILTER_LEN + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } evt_t;

    logic ps2_clk   = 1'b0;
    logic rst_n     = 1'b0;
    logic line_clk  = 1'b1;
    logic line_data = 1'b1;

    ps2_rx_if u_bus ();

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .ps2_clk           (ps2_clk),
        .rst_n             (rst_n),
        .ps2_line_clk_i    (line_clk),
        .ps2_line_data_i   (line_data),
        .ps2_key_data_o    (u_bus.key_data),
        .ps2_key_data_en_o (u_bus.key_data_en),
        .ps2_frame_err_o   (u_bus.frame_err)
    );

    always #5 ps2_clk = ~ps2_clk;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         last_fall_cyc = 0;
    int         err_cyc = -1;
    logic [7:0] exp_data = 8'h00;
    evt_t       sb[$];

    always @(posedge ps2_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected event.
    always @(negedge ps2_clk) begin
        if (rst_n && (u_bus.key_data_en || u_bus.frame_err)) begin
            check("strobe_excl", 32'(u_bus.key_data_en & u_bus.frame_err), 0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'b0, u_bus.frame_err, u_bus.key_data_en}, 0);
            end else begin
                evt_t e;
                e = sb.pop_front();
                check("strobe_kind", 32'(u_bus.frame_err), 32'(e.is_err));
                check("key_data", 32'(u_bus.key_data), 32'(e.data));
                if (u_bus.frame_err) err_cyc = cyc;
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge ps2_clk);
        line_data = b;
        repeat (HALF_BIT) @(negedge ps2_clk);
        line_clk      = 1'b0;
        last_fall_cyc = cyc;
        repeat (HALF_BIT) @(negedge ps2_clk);
        line_clk = 1'b1;
    endtask

    task automatic push_evt(input bit is_err, input logic [7:0] d);
        evt_t e;
        e.is_err = is_err;
        e.data   = d;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit parity_good);
        logic p;
        p = parity_good ? ~^d : ^d;
`ifdef PS2_RX_PARITY_CHECK_EN
        if (parity_good) begin
            exp_data = d;
            push_evt(1'b0, d);
        end else begin
            push_evt(1'b1, exp_data);
        end
`else
        exp_data = d;
        push_evt(1'b0, d);
`endif
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(1'b1);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge ps2_clk);
        check(tag, sb.size(), 0);
    endtask

    initial begin
        repeat (200000) @(posedge ps2_clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (4) @(negedge ps2_clk);
        check("rst_data", 32'(u_bus.key_data), 0);
        check("rst_en", 32'(u_bus.key_data_en), 0);
        check("rst_err", 32'(u_bus.frame_err), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge ps2_clk);

        // Single frame, parity 0, stop 1.
        send_frame(8'h75, 1'b1);
        drain("drain_75", 4 * PIPE);
        check("hold_75", 32'(u_bus.key_data), 32'h75);

        // Back-to-back frames.
        send_frame(8'hE0, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h6B, 1'b1);
        drain("drain_b2b", 4 * PIPE);

        // Wrong parity.
        send_frame(8'h1C, 1'b0);
        drain("drain_par", 4 * PIPE);
        check("hold_par", 32'(u_bus.key_data), 32'(exp_data));

        // Short low glitch on the clock line while data is low.
        @(negedge ps2_clk);
        line_data = 1'b0;
        repeat (5) @(negedge ps2_clk);
        line_clk = 1'b0;
        repeat (3) @(negedge ps2_clk);
        line_clk = 1'b1;
        repeat (5) @(negedge ps2_clk);
        line_data = 1'b1;
        repeat (60) @(negedge ps2_clk);
        check("glitch_quiet", sb.size(), 0);
        send_frame(8'hA5, 1'b1);
        drain("drain_glitch", 4 * PIPE);

        // Clocking stops after 4 data bits.
        push_evt(1'b1, exp_data);
        err_cyc = -1;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        drain("drain_timeout", 2 * TIMEOUT_CYCLES + 4 * PIPE);
        check("timeout_latency", 32'(err_cyc - last_fall_cyc), 32'(PIPE + TIMEOUT_CYCLES));
        send_frame(8'h31, 1'b1);
        drain("drain_31", 4 * PIPE);

        // Reset in the middle of a frame.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge ps2_clk);
        rst_n     = 1'b0;
        line_data = 1'b1;
        exp_data  = 8'h00;
        repeat (3) @(negedge ps2_clk);
        check("midrst_data", 32'(u_bus.key_data), 0);
        rst_n = 1'b1;
        repeat (4 * PIPE) @(negedge ps2_clk);
        check("midrst_quiet", sb.size(), 0);
        send_frame(8'h29, 1'b1);
        drain("drain_29", 4 * PIPE);
        check("hold_29", 32'(u_bus.key_data), 32'h29);

        repeat (50) @(negedge ps2_clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive identical samples needed to accept a PS/2 line level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: idle clock cycles inside a frame before it is aborted.
REQ-003 SHALL have port ps2_clk  input  1: the single clock; all logic is rising-edge on ps2_clk.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port ps2_line_clk_i  input  1: raw PS/2 clock line, asynchronous to ps2_clk.
REQ-006 SHALL have port ps2_line_data_i  input  1: raw PS/2 data line, asynchronous to ps2_clk.
REQ-007 SHALL have port ps2_key_data_o  output  8: last received scan-code byte, held between strobes.
REQ-008 SHALL have port ps2_key_data_en_o  output  1: one-cycle strobe marking a new valid byte on ps2_key_data_o.
REQ-009 SHALL have port ps2_frame_err_o  output  1: one-cycle strobe marking a dropped frame.

Function
REQ-010 SHALL pass both line inputs through a 2-FF synchronizer, then a filter that changes filtered level only after FILTER_LEN equal synchronized samples.
REQ-011 SHALL detect a falling edge of the filtered clock line and sample the filtered data line in that same cycle.
REQ-012 SHALL implement FSM IDLE -> DATA (8 bits, LSB first, 3-bit counter) -> PARITY -> STOP -> IDLE, one state step per falling edge.
REQ-013 SHALL leave IDLE only when the sampled start bit is 0; a sampled 1 in IDLE is ignored with no error.
REQ-014 SHALL compute odd parity over the 8 data bits plus parity bit (XOR of 9 bits must equal 1).
REQ-015 SHALL, on stop bit 1 with parity good, update ps2_key_data_o and pulse ps2_key_data_en_o in the cycle after the stop-bit falling edge (latency 1 cycle).
REQ-016 SHALL, on stop bit 0, drop the byte, leave ps2_key_data_o unchanged, pulse ps2_frame_err_o, return to IDLE.
REQ-017 SHALL reset a timeout counter (width $clog2(TIMEOUT_CYCLES+1)) on each filtered falling edge and hold it at 0 in IDLE.
REQ-018 SHALL, when not IDLE and the counter reaches TIMEOUT_CYCLES, abort to IDLE and pulse ps2_frame_err_o; counter saturates, no wrap.
REQ-019 SHALL never assert ps2_key_data_en_o and ps2_frame_err_o in the same cycle.
REQ-020 SHALL accept back-to-back frames (start bit immediately after stop bit) with no lost byte.

Reset
REQ-021 SHALL on rst_n low immediately set FSM to IDLE, bit counter and timeout counter to 0, ps2_key_data_o to 8'h00, both strobes to 0, synchronizer and filter state to 1 (idle line level).
REQ-022 SHALL discard any partial frame when reset is asserted mid-frame and emit no strobe on release.

Configuration
REQ-023 SHALL use macro PS2_RX_PARITY_CHECK_EN: when defined, a parity failure drops the byte and pulses ps2_frame_err_o in the cycle after stop.
REQ-024 SHALL, with PS2_RX_PARITY_CHECK_EN undefined, ignore the parity bit and deliver the byte whenever the stop bit is 1.

Structure
REQ-025 SHALL place the FSM state enum (IDLE, DATA, PARITY, STOP) and the frame constants (8 data bits, start 0, stop 1) in shared package ps2_pkg.
REQ-026 SHALL place the synchronizer and FILTER_LEN filter in sub-module ps2_line_filter, instantiated once per line.
REQ-027 SHALL connect ps2_key_data_o and ps2_key_data_en_o directly to user_input ps2_key_data_i and ps2_key_data_en_i on the same ps2_clk.

Verification
REQ-028 SHALL cover: a frame for 8'h75 with parity 0 and stop 1 -> exactly one en pulse, data 8'h75, no err.
REQ-029 SHALL cover: back-to-back frames E0, F0, 6B -> three en pulses, data E0 then F0 then 6B, no err.
REQ-030 SHALL cover: 8'h1C sent with wrong parity and the macro defined -> no en, one err pulse, data keeps its previous value; with the macro undefined -> en with data 8'h1C.
REQ-031 SHALL cover: a 3-cycle low glitch on ps2_line_clk_i with FILTER_LEN=8 -> no state change, no strobe.
REQ-032 SHALL cover: clocking stopped after 4 data bits with TIMEOUT_CYCLES=200 -> err pulse exactly 200 cycles after the last falling edge, then a frame for 8'h31 -> en with data 8'h31.
REQ-033 SHALL cover: rst_n pulsed low mid-frame, then a full frame for 8'h29 -> single en with data 8'h29, no err.
